c2h_stream_adapter: RTL and testbench
=====================================

Name: c2h_stream_adapter

Overview:
- Sits directly downstream of the C2H traffic generator, between its beat stream (rx_valid/rx_data/rx_last/rx_qid, transfer when rx_valid & rx_ready) and the QDMA C2H AXI-Stream and completion (CMPT) interfaces.
- Registers each beat through a 2-entry skid buffer. Attaches per-packet ctrl_len/ctrl_qid/mty, checks beat count against the programmed length, and emits one completion entry per packet from a small FIFO.
- Keeps packet and error statistics for the control-register block.

Parameters:
- DATA_W, 512, stream data width in bits; BEAT_BYTES = DATA_W/8.
- QID_W, 11, queue id width.
- LEN_W, 16, packet length width in bytes.
- CMPT_DEPTH, 8, completion FIFO depth (power of 2, >=2).

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  synchronous active-high reset.
- rx_valid  in  1  beat valid from generator.
- rx_data  in  DATA_W  beat data.
- rx_last  in  1  last beat of packet.
- rx_qid  in  QID_W  queue id, sampled on first beat.
- txr_size  in  LEN_W  packet length in bytes, sampled on first beat.
- rx_ready  out  1  beat accept.
- m_axis_c2h_tvalid  out  1  output beat valid.
- m_axis_c2h_tready  in  1  QDMA accept.
- m_axis_c2h_tdata  out  DATA_W  output data.
- m_axis_c2h_tlast  out  1  last beat.
- m_axis_c2h_mty  out  6  empty bytes on last beat, 0 otherwise.
- m_axis_c2h_ctrl_len  out  LEN_W  packet length, constant across the packet.
- m_axis_c2h_ctrl_qid  out  QID_W  packet queue id, constant across the packet.
- cmpt_tvalid  out  1  completion entry valid.
- cmpt_tready  in  1  completion accept.
- cmpt_tdata  out  64  {err[63], rsvd[62:59], qid[58:48] (QID_W=11), seq[47:16], len[15:0]}.
- clr_stat  in  1  clears statistics.
- pkt_cnt  out  32  packets completed (wraps).
- err_cnt  out  16  length-mismatch packets (saturates at 0xFFFF).
- err_sticky  out  1  set on any mismatch.

Behaviour:
- Reset: all outputs 0. Skid buffer, CMPT FIFO, reservation count, beat counter and in_pkt cleared. seq = 0. In-flight beats are discarded. rx_ready = 0 while axi_areset is high.
- Accept: beat accepted when rx_valid & rx_ready.
- rx_ready = skid_has_space & (in_pkt | cmpt_resv < CMPT_DEPTH).
  - skid_has_space is registered: low only when both skid entries are full.
- First beat (in_pkt=0):
  - latch len = txr_size and qid = rx_qid.
  - exp_beats = ceil(len/BEAT_BYTES); len 0 is treated as 1 beat.
  - increment cmpt_resv (reserve a slot), set beat_cnt = 1, set in_pkt.
- Later beats: beat_cnt++, saturating at 2^LEN_W-1.
- Latency: a beat accepted at edge N is presented on m_axis_c2h at N+1.
- Ordering and metadata: beats leave in order. tdata/tlast pass through. ctrl_len/ctrl_qid carry the latched values. mty = (BEAT_BYTES - len mod BEAT_BYTES) mod BEAT_BYTES on tlast beats, 0 on other beats.
- Output hold: while tvalid & ~tready, all m_axis_c2h outputs hold stable. A beat is never dropped or duplicated. Zero-bubble throughput when tready is held high.
- Mismatch: err = (beat_cnt != exp_beats) evaluated at the accepted rx_last beat. A beat with beat_cnt > exp_beats and no rx_last also sets err. The packet is still forwarded unchanged and tlast follows rx_last.
- Completion push: on the accepted rx_last beat, push {err, qid, seq, len} into the CMPT FIFO, then seq++, clear in_pkt, pkt_cnt++. If err, err_cnt++ and err_sticky = 1.
  - The push cannot overflow, because a slot was reserved at the first beat.
- Completion pop: on cmpt_tvalid & cmpt_tready, pop the FIFO and decrement cmpt_resv.
  - Same-cycle reserve and pop leave cmpt_resv unchanged.
  - Same-cycle push and pop leave the FIFO count unchanged.
- Completion timing: cmpt_tvalid = FIFO non-empty. Completion may be presented before the data tlast leaves the skid. The QDMA tolerates this ordering.
- Single-beat packet: the first beat is also rx_last. Reservation and push happen in the same cycle.
- clr_stat: pkt_cnt, err_cnt and err_sticky go to 0 next cycle. If a completion happens in the same cycle, the clear wins and that packet is not counted.
- Back-pressure: CMPT FIFO full (cmpt_resv == CMPT_DEPTH) blocks only new packet starts. Beats of a packet already in progress continue.

Test Plan:
- Stream test: reset, then 4 packets of txr_size=256 (4 beats each), tready=1, cmpt_tready=1 -> 16 contiguous beats, one-cycle latency, tlast on beats 4/8/12/16, mty=0. cmpt seq 0..3 with len=0x100, err=0. pkt_cnt=4.
- mty and single-beat test: txr_size=100 -> 2 beats, mty=28 on beat 2. txr_size=64 -> single beat with tlast=1, mty=0. txr_size=0 -> single beat, no error.
- Random back-pressure test: toggle m_axis_c2h_tready randomly over 50 packets of 192 B -> output beat sequence identical to input and data stable while stalled. rx_ready drops only with both skid entries full.
- CMPT-full test: cmpt_tready=0, send 10 single-beat packets -> exactly 8 accepted, then rx_ready=0 at the next packet start. Raising cmpt_tready for one cycle admits exactly one more packet.
- Length-mismatch test: txr_size=256 but rx_last on beat 3 -> forwarded with tlast on beat 3, cmpt err=1, err_cnt=1, err_sticky=1. clr_stat then zeroes all three statistics.
- Reset mid-packet test: assert axi_areset after beat 2 of 4 -> all outputs 0, seq=0. The next packet completes normally with seq=0.

Source files
------------

// File: rtl/c2h_stream_adapter_if.sv
// c2h_stream_adapter_if: generator beat stream, QDMA C2H stream and completion channel bundle
interface c2h_stream_adapter_if #(
    parameter int DATA_W = 512,
    parameter int QID_W  = 11,
    parameter int LEN_W  = 16
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_last;
    logic [QID_W-1:0]  rx_qid;
    logic [LEN_W-1:0]  txr_size;
    logic              rx_ready;
    logic              m_axis_c2h_tvalid;
    logic              m_axis_c2h_tready;
    logic [DATA_W-1:0] m_axis_c2h_tdata;
    logic              m_axis_c2h_tlast;
    logic [5:0]        m_axis_c2h_mty;
    logic [LEN_W-1:0]  m_axis_c2h_ctrl_len;
    logic [QID_W-1:0]  m_axis_c2h_ctrl_qid;
    logic              cmpt_tvalid;
    logic              cmpt_tready;
    logic [63:0]       cmpt_tdata;
    modport master (
        output rx_valid, rx_data, rx_last, rx_qid, txr_size, m_axis_c2h_tready, cmpt_tready,
        input  rx_ready, m_axis_c2h_tvalid, m_axis_c2h_tdata, m_axis_c2h_tlast, m_axis_c2h_mty,
               m_axis_c2h_ctrl_len, m_axis_c2h_ctrl_qid, cmpt_tvalid, cmpt_tdata
    );
    modport slave (
        input  rx_valid, rx_data, rx_last, rx_qid, txr_size, m_axis_c2h_tready, cmpt_tready,
        output rx_ready, m_axis_c2h_tvalid, m_axis_c2h_tdata, m_axis_c2h_tlast, m_axis_c2h_mty,
               m_axis_c2h_ctrl_len, m_axis_c2h_ctrl_qid, cmpt_tvalid, cmpt_tdata
    );
endinterface

// File: rtl/c2h_stream_adapter.sv
// c2h_stream_adapter: skid-buffered C2H beat forwarding with per-packet metadata, length check and completions
module c2h_stream_adapter #(
    parameter int DATA_W     = 512,
    parameter int QID_W      = 11,
    parameter int LEN_W      = 16,
    parameter int CMPT_DEPTH = 8
) (
    input  logic                axi_aclk,
    input  logic                axi_areset,
    c2h_stream_adapter_if.slave bus,
    input  logic                clr_stat,
    output logic [31:0]         pkt_cnt,
    output logic [15:0]         err_cnt,
    output logic                err_sticky
);
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int SH = $clog2(BEAT_BYTES);
    localparam int AW = $clog2(CMPT_DEPTH);
    localparam logic [AW:0] CMPT_FULL = (AW+1)'(CMPT_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [5:0]        mty;
        logic [LEN_W-1:0]  len;
        logic [QID_W-1:0]  qid;
    } beat_t;

    beat_t            skid [2];
    logic             skid_wp, skid_rp;
    logic [1:0]       skid_cnt;
    logic             in_pkt, pkt_err;
    logic [LEN_W-1:0] len_q, exp_q, beat_cnt;
    logic [QID_W-1:0] qid_q;
    logic [31:0]      seq;
    logic [AW:0]      cmpt_resv, cmpt_cnt;
    logic [AW-1:0]    cmpt_wp, cmpt_rp;
    logic [63:0]      cmpt_mem [CMPT_DEPTH];

    logic             skid_has_space, acc, out_pop, start, push, pop, err_now;
    logic [LEN_W-1:0] cur_len, cur_exp, cur_cnt, size_exp;
    logic [QID_W-1:0] cur_qid;
    logic [SH-1:0]    tail;
    logic [63:0]      cmpt_entry;
    beat_t            in_beat, head;

    assign skid_has_space = skid_cnt != 2'd2;
    assign bus.rx_ready   = ~axi_areset & skid_has_space & (in_pkt | (cmpt_resv < CMPT_FULL));
    assign acc     = bus.rx_valid & bus.rx_ready;
    assign start   = acc & ~in_pkt;
    assign push    = acc & bus.rx_last;
    assign out_pop = bus.m_axis_c2h_tvalid & bus.m_axis_c2h_tready;
    assign pop     = bus.cmpt_tvalid & bus.cmpt_tready;

    // A zero-length packet still occupies one beat
    assign size_exp = (bus.txr_size >> SH) + LEN_W'((bus.txr_size[SH-1:0] != '0) || (bus.txr_size == '0));
    assign cur_len  = in_pkt ? len_q : bus.txr_size;
    assign cur_qid  = in_pkt ? qid_q : bus.rx_qid;
    assign cur_exp  = in_pkt ? exp_q : size_exp;
    assign cur_cnt  = in_pkt ? (beat_cnt == '1 ? beat_cnt : beat_cnt + LEN_W'(1)) : LEN_W'(1);
    assign err_now  = pkt_err | (bus.rx_last ? cur_cnt != cur_exp : cur_cnt > cur_exp);
    assign tail     = SH'(0) - cur_len[SH-1:0];
    assign in_beat  = '{data: bus.rx_data, last: bus.rx_last, mty: bus.rx_last ? 6'(tail) : 6'd0,
                        len: cur_len, qid: cur_qid};
    assign cmpt_entry = {err_now, {(15-QID_W){1'b0}}, cur_qid, seq, 16'(cur_len)};

    assign bus.m_axis_c2h_tvalid   = skid_cnt != 2'd0;
    assign head                    = bus.m_axis_c2h_tvalid ? skid[skid_rp] : '0;
    assign bus.m_axis_c2h_tdata    = head.data;
    assign bus.m_axis_c2h_tlast    = head.last;
    assign bus.m_axis_c2h_mty      = head.mty;
    assign bus.m_axis_c2h_ctrl_len = head.len;
    assign bus.m_axis_c2h_ctrl_qid = head.qid;
    assign bus.cmpt_tvalid         = cmpt_cnt != '0;
    assign bus.cmpt_tdata          = bus.cmpt_tvalid ? cmpt_mem[cmpt_rp] : '0;

    always_ff @(posedge axi_aclk) begin
        if (acc) skid[skid_wp] <= in_beat;
        if (push) cmpt_mem[cmpt_wp] <= cmpt_entry;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            skid_wp    <= 1'b0;
            skid_rp    <= 1'b0;
            skid_cnt   <= 2'd0;
            in_pkt     <= 1'b0;
            pkt_err    <= 1'b0;
            len_q      <= '0;
            exp_q      <= '0;
            beat_cnt   <= '0;
            qid_q      <= '0;
            seq        <= '0;
            cmpt_resv  <= '0;
            cmpt_cnt   <= '0;
            cmpt_wp    <= '0;
            cmpt_rp    <= '0;
            pkt_cnt    <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (acc) skid_wp <= ~skid_wp;
            if (out_pop) skid_rp <= ~skid_rp;
            skid_cnt <= skid_cnt + 2'(acc) - 2'(out_pop);
            if (acc) begin
                in_pkt   <= ~bus.rx_last;
                pkt_err  <= ~bus.rx_last & err_now;
                len_q    <= cur_len;
                qid_q    <= cur_qid;
                exp_q    <= cur_exp;
                beat_cnt <= cur_cnt;
            end
            cmpt_resv <= cmpt_resv + (AW+1)'(start) - (AW+1)'(pop);
            cmpt_cnt  <= cmpt_cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (push) cmpt_wp <= cmpt_wp + AW'(1);
            if (pop) cmpt_rp <= cmpt_rp + AW'(1);
            if (push) seq <= seq + 32'd1;
            // A clear in the same cycle as a completion drops that packet from the stats
            if (clr_stat) begin
                pkt_cnt    <= '0;
                err_cnt    <= '0;
                err_sticky <= 1'b0;
            end else if (push) begin
                pkt_cnt <= pkt_cnt + 32'd1;
                if (err_now) begin
                    err_cnt    <= err_cnt == 16'hFFFF ? err_cnt : err_cnt + 16'd1;
                    err_sticky <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_c2h_stream_adapter.sv
// tb_c2h_stream_adapter: directed scoreboard bench for the C2H stream adapter
module tb_c2h_stream_adapter;
    typedef struct packed {
        logic [511:0] data;
        logic         last;
        logic [5:0]   mty;
        logic [15:0]  len;
        logic [10:0]  qid;
    } beat_t;

    logic        clk, rst, clr;
    logic [31:0] pkt_cnt;
    logic [15:0] err_cnt;
    logic        err_sticky;
    int          passed, total, cyc, beat_id, occ;
    logic [31:0] seq_m;
    bit          chk_ready, bp_en, prev_stall;
    beat_t       qb[$];
    logic [63:0] qc[$];
    beat_t       mgot, mexp, held;
    logic [63:0] cexp;

    c2h_stream_adapter_if #(.DATA_W(512), .QID_W(11), .LEN_W(16)) bus ();

    c2h_stream_adapter #(.DATA_W(512), .QID_W(11), .LEN_W(16), .CMPT_DEPTH(8)) dut (
        .axi_aclk(clk), .axi_areset(rst), .bus(bus), .clr_stat(clr),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [599:0] got, input logic [599:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    // Beat/completion monitor with a skid occupancy model built from observed handshakes
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_reset", bus.rx_ready, 0);
            occ = 0;
            prev_stall = 0;
        end else begin
            mgot = '{data: bus.m_axis_c2h_tdata, last: bus.m_axis_c2h_tlast, mty: bus.m_axis_c2h_mty,
                     len: bus.m_axis_c2h_ctrl_len, qid: bus.m_axis_c2h_ctrl_qid};
            if (chk_ready) chk("rx_ready_occ", bus.rx_ready, occ < 2);
            chk("tvalid_occ", bus.m_axis_c2h_tvalid, occ != 0);
            if (prev_stall) chk("hold", {bus.m_axis_c2h_tvalid, mgot}, {1'b1, held});
            if (bus.m_axis_c2h_tvalid && bus.m_axis_c2h_tready) begin
                if (qb.size() == 0) chk("beat_unexpected", qb.size(), 1);
                else begin
                    mexp = qb.pop_front();
                    chk("beat", mgot, mexp);
                end
            end
            if (bus.cmpt_tvalid && bus.cmpt_tready) begin
                if (qc.size() == 0) chk("cmpt_unexpected", qc.size(), 1);
                else begin
                    cexp = qc.pop_front();
                    chk("cmpt", bus.cmpt_tdata, cexp);
                end
            end
            prev_stall = bus.m_axis_c2h_tvalid && !bus.m_axis_c2h_tready;
            held = mgot;
            occ += int'(bus.rx_valid && bus.rx_ready) - int'(bus.m_axis_c2h_tvalid && bus.m_axis_c2h_tready);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bp_en) bus.m_axis_c2h_tready = 1'($urandom_range(0, 1));
    end

    task automatic drive_beat(input logic [511:0] d, input logic last, input logic [10:0] dq,
                              input logic [15:0] ds, input beat_t e, input int max_wait, output bit ok);
        bus.rx_valid = 1;
        bus.rx_data = d;
        bus.rx_last = last;
        bus.rx_qid = dq;
        bus.txr_size = ds;
        ok = 0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            ok = bus.rx_ready;
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 0;
        if (ok) qb.push_back(e);
    endtask

    // Later beats carry scrambled size/qid to prove the first-beat values are latched
    task automatic send_pkt(input logic [15:0] size, input logic [10:0] qid, input int nb, input logic [5:0] mty,
                            input logic err, input int max_wait, output bit ok);
        beat_t e;
        logic [31:0] w;
        ok = 1;
        for (int b = 0; b < nb && ok; b++) begin
            w = 32'(beat_id) * 32'h9E3779B1 + 32'h1357;
            e = '{data: {16{w}}, last: (b == nb - 1), mty: (b == nb - 1) ? mty : 6'd0, len: size, qid: qid};
            drive_beat(e.data, e.last, b == 0 ? qid : ~qid, b == 0 ? size : ~size, e, max_wait, ok);
            if (ok) beat_id++;
        end
        if (ok) begin
            qc.push_back({err, 4'b0, qid, seq_m, size});
            seq_m++;
        end
    endtask

    task automatic pkt(input logic [15:0] size, input logic [10:0] qid, input int nb, input logic [5:0] mty,
                       input logic err);
        bit ok;
        send_pkt(size, qid, nb, mty, err, 400, ok);
        chk("pkt_accept", ok, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((qb.size() != 0 || qc.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", qb.size() + qc.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_c2h"}, {bus.m_axis_c2h_tvalid, bus.m_axis_c2h_tdata, bus.m_axis_c2h_tlast, bus.m_axis_c2h_mty,
                            bus.m_axis_c2h_ctrl_len, bus.m_axis_c2h_ctrl_qid}, 0);
        chk({tag, "_cmpt"}, {bus.cmpt_tvalid, bus.cmpt_tdata, pkt_cnt, err_cnt, err_sticky}, 0);
    endtask

    initial begin
        bit ok;
        int c0;
        rst = 1;
        clr = 0;
        bus.rx_valid = 0;
        bus.rx_data = '0;
        bus.rx_last = 0;
        bus.rx_qid = '0;
        bus.txr_size = '0;
        bus.m_axis_c2h_tready = 1;
        bus.cmpt_tready = 1;
        seq_m = 0;
        chk_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int p = 0; p < 4; p++) pkt(16'd256, 11'(5 + p), 4, 6'd0, 1'b0);
        chk("stream_cycles", cyc - c0, 16);
        drain();
        chk("pkt_cnt_stream", pkt_cnt, 4);

        pkt(16'd100, 11'd3, 2, 6'd28, 1'b0);
        pkt(16'd64, 11'd9, 1, 6'd0, 1'b0);
        @(negedge clk);
        chk("latency_single", {bus.m_axis_c2h_tvalid, bus.m_axis_c2h_tlast, bus.m_axis_c2h_ctrl_len}, {2'b11, 16'd64});
        @(posedge clk);
        #1;
        pkt(16'd0, 11'd10, 1, 6'd0, 1'b0);
        drain();
        chk("pkt_cnt_mty", pkt_cnt, 7);

        bp_en = 1;
        for (int p = 0; p < 50; p++) pkt(16'd192, 11'(100 + p), 3, 6'd0, 1'b0);
        bp_en = 0;
        @(posedge clk);
        #1;
        bus.m_axis_c2h_tready = 1;
        drain();
        chk("pkt_cnt_bp", pkt_cnt, 57);

        pkt(16'd256, 11'd7, 3, 6'd0, 1'b1);
        drain();
        chk("err_stats", {pkt_cnt, err_cnt, err_sticky}, {32'd58, 16'd1, 1'b1});
        clr = 1;
        @(posedge clk);
        #1;
        clr = 0;
        chk("clr_stats", {pkt_cnt, err_cnt, err_sticky}, 0);

        chk_ready = 0;
        bus.cmpt_tready = 0;
        for (int p = 0; p < 8; p++) pkt(16'd64, 11'(20 + p), 1, 6'd0, 1'b0);
        send_pkt(16'd64, 11'd28, 1, 6'd0, 1'b0, 5, ok);
        chk("cmpt_full_block", ok, 0);
        bus.cmpt_tready = 1;
        @(posedge clk);
        #1;
        bus.cmpt_tready = 0;
        send_pkt(16'd64, 11'd28, 1, 6'd0, 1'b0, 4, ok);
        chk("cmpt_one_more", ok, 1);
        send_pkt(16'd64, 11'd29, 1, 6'd0, 1'b0, 5, ok);
        chk("cmpt_full_again", ok, 0);
        bus.cmpt_tready = 1;
        drain();
        chk("pkt_cnt_cmpt", pkt_cnt, 9);
        chk_ready = 1;

        begin
            beat_t e;
            for (int b = 0; b < 2; b++) begin
                e = '{data: {16{32'hA5A5_0000 + 32'(b)}}, last: 1'b0, mty: 6'd0, len: 16'd256, qid: 11'd12};
                drive_beat(e.data, 1'b0, 11'd12, 16'd256, e, 50, ok);
                chk("mid_reset_beat", ok, 1);
            end
        end
        rst = 1;
        qb.delete();
        qc.delete();
        seq_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        pkt(16'd256, 11'd11, 4, 6'd0, 1'b0);
        drain();
        chk("pkt_cnt_after_reset", pkt_cnt, 1);
        chk("queues_empty", qb.size() + qc.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
